// File: rtl/log_event_mux.sv
// Merges log events from several sources into one FIFO-buffered stream.
// It filters INFO events by verbosity and keeps saturating per-severity statistics.
module log_event_mux #(
    parameter int NUM_SRC    = 4,
    parameter int MSG_WIDTH  = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 16,
    localparam int SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_SRC-1:0]           src_valid,
    output logic [NUM_SRC-1:0]           src_ready,
    input  logic [3*NUM_SRC-1:0]         src_level,
    input  logic [2*NUM_SRC-1:0]         src_sev,
    input  logic [MSG_WIDTH*NUM_SRC-1:0] src_msg,
    input  logic [2:0]                   cfg_verbosity,
    input  logic                         cnt_clear,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SRC_W-1:0]             out_src,
    output logic [2:0]                   out_level,
    output logic [1:0]                   out_sev,
    output logic [MSG_WIDTH-1:0]         out_msg,
    output logic [CNT_WIDTH-1:0]         cnt_warn,
    output logic [CNT_WIDTH-1:0]         cnt_error,
    output logic [CNT_WIDTH-1:0]         cnt_fatal,
    output logic [CNT_WIDTH-1:0]         cnt_drop,
    output logic                         fatal_seen
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int ENT_W = SRC_W + 3 + 2 + MSG_WIDTH;

    logic [SRC_W-1:0]     rr_ptr;
    logic [SRC_W-1:0]     grant;
    logic                 found;
    logic [2:0]           g_level;
    logic [1:0]           g_sev;
    logic [MSG_WIDTH-1:0] g_msg;
    logic [2:0]           eff_verb;
    logic                 g_pass;
    logic                 hs;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;

    logic [ENT_W-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          fifo_cnt;
    logic [ENT_W-1:0]     head;

    // Round-robin search begins at rr_ptr and takes the first valid source.
    always_comb begin
        int idx;
        idx   = 0;
        grant = rr_ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (!found && src_valid[SRC_W'(idx)]) begin
                grant = SRC_W'(idx);
                found = 1'b1;
            end
        end
    end

    assign g_level  = src_level[3*grant +: 3];
    assign g_sev    = src_sev[2*grant +: 2];
    assign g_msg    = src_msg[MSG_WIDTH*grant +: MSG_WIDTH];
    assign eff_verb = (cfg_verbosity > 3'd4) ? 3'd4 : cfg_verbosity;
    assign g_pass   = (g_sev != 2'd0) ||
                      ((eff_verb != 3'd0) && (g_level != 3'd0) && (g_level <= eff_verb));

    assign fifo_full = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
    assign out_valid = (fifo_cnt != '0);

    // Filtered events are never stored, so they drain even when the FIFO is full.
    always_comb begin
        src_ready = '0;
        if (!rst) src_ready[grant] = g_pass ? !fifo_full : 1'b1;
    end

    assign hs   = src_valid[grant] & src_ready[grant];
    assign push = hs & g_pass;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) rr_ptr <= '0;
        else if (hs) rr_ptr <= (int'(grant) == NUM_SRC - 1) ? '0 : grant + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {grant, g_level, g_sev, g_msg};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
            else if (!push && pop) fifo_cnt <= fifo_cnt - 1'b1;
        end
    end

    assign head = mem[rd_ptr];
    assign {out_src, out_level, out_sev, out_msg} = out_valid ? head : '0;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            cnt_warn  <= '0;
            cnt_error <= '0;
            cnt_fatal <= '0;
            cnt_drop  <= '0;
        end else if (hs) begin
            case (g_sev)
                2'd1:    cnt_warn  <= sat_inc(cnt_warn);
                2'd2:    cnt_error <= sat_inc(cnt_error);
                2'd3:    cnt_fatal <= sat_inc(cnt_fatal);
                default: if (!g_pass) cnt_drop <= sat_inc(cnt_drop);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) fatal_seen <= 1'b0;
        else if (hs && (g_sev == 2'd3)) fatal_seen <= 1'b1;
    end

endmodule

// File: tb/tb_log_event_mux.sv
// Directed bench for log_event_mux with 4 sources, an 8-deep FIFO and 4-bit counters.
module tb_log_event_mux;

    localparam int NUM_SRC = 4;
    localparam int MW      = 32;
    localparam int CW      = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        src_valid;
    logic [3:0]        src_ready;
    logic [11:0]       src_level;
    logic [7:0]        src_sev;
    logic [127:0]      src_msg;
    logic [2:0]        cfg_verbosity;
    logic              cnt_clear;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_src;
    logic [2:0]        out_level;
    logic [1:0]        out_sev;
    logic [MW-1:0]     out_msg;
    logic [CW-1:0]     cnt_warn, cnt_error, cnt_fatal, cnt_drop;
    logic              fatal_seen;

    int errors = 0;
    int checks = 0;

    log_event_mux #(.NUM_SRC(NUM_SRC), .MSG_WIDTH(MW), .FIFO_DEPTH(8), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_level(src_level), .src_sev(src_sev), .src_msg(src_msg),
        .cfg_verbosity(cfg_verbosity), .cnt_clear(cnt_clear),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_src(out_src), .out_level(out_level), .out_sev(out_sev), .out_msg(out_msg),
        .cnt_warn(cnt_warn), .cnt_error(cnt_error), .cnt_fatal(cnt_fatal),
        .cnt_drop(cnt_drop), .fatal_seen(fatal_seen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [2:0] lvl, input logic [1:0] sev,
                           input logic [31:0] msg);
        src_level[3*i +: 3] = lvl;
        src_sev[2*i +: 2]   = sev;
        src_msg[32*i +: 32] = msg;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        src_valid = '0;
        cnt_clear = 1'b0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        // 1: reset with all sources requesting
        rst = 1'b1; src_valid = 4'hF; src_level = '0; src_sev = '0; src_msg = '0;
        cfg_verbosity = 3'd4; cnt_clear = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) set_src(i, 3'd1, 2'd1, 32'd0);
        #1 chk("rst_ready0", 64'(src_ready), 64'h0);
        tick();
        chk("rst_ready1", 64'(src_ready), 64'h0);
        tick();
        rst = 1'b0; src_valid = '0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_msg", 64'(out_msg), 64'h0);
        chk("rst_cnt_warn", 64'(cnt_warn), 64'h0);
        chk("rst_cnt_error", 64'(cnt_error), 64'h0);
        chk("rst_cnt_fatal", 64'(cnt_fatal), 64'h0);
        chk("rst_cnt_drop", 64'(cnt_drop), 64'h0);
        chk("rst_fatal_seen", 64'(fatal_seen), 64'h0);

        // 2: round-robin fairness
        for (int i = 0; i < 4; i++) set_src(i, 3'd1, 2'd1, 32'(100 + i));
        src_valid = 4'hF; out_ready = 1'b1;
        #1;
        chk("rr_first_ready", 64'(src_ready), 64'h1);
        chk("rr_no_early_valid", 64'(out_valid), 64'h0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rr_out_valid", 64'(out_valid), 64'h1);
            chk("rr_out_src", 64'(out_src), 64'(k % 4));
            chk("rr_out_msg", 64'(out_msg), 64'(100 + k % 4));
            chk("rr_cnt_warn", 64'(cnt_warn), 64'(k + 1));
        end
        src_valid = '0;
        tick();
        chk("rr_drained", 64'(out_valid), 64'h0);

        // 3: verbosity filtering
        do_reset();
        cfg_verbosity = 3'd2; out_ready = 1'b0; src_valid = 4'b0010;
        for (int l = 1; l <= 4; l++) begin
            set_src(1, 3'(l % 4), 2'd0, 32'(200 + l % 4));
            #1 chk("flt_ready", 64'(src_ready), 64'h2);
            tick();
        end
        src_valid = '0;
        #1;
        chk("flt_cnt_drop", 64'(cnt_drop), 64'h2);
        chk("flt_head_level", 64'(out_level), 64'h1);
        chk("flt_head_msg", 64'(out_msg), 64'd201);
        chk("flt_head_src", 64'(out_src), 64'h1);
        out_ready = 1'b1;
        tick();
        chk("flt_second_level", 64'(out_level), 64'h2);
        tick();
        chk("flt_empty", 64'(out_valid), 64'h0);
        cfg_verbosity = 3'd0;
        set_src(1, 3'd1, 2'd0, 32'd300);
        src_valid = 4'b0010;
        tick();
        src_valid = '0;
        #1;
        chk("flt_verb0_drop", 64'(cnt_drop), 64'h3);
        chk("flt_verb0_empty", 64'(out_valid), 64'h0);
        cfg_verbosity = 3'd7;
        set_src(1, 3'd4, 2'd0, 32'd304);
        src_valid = 4'b0010;
        tick();
        src_valid = '0;
        #1;
        chk("flt_verb7_pass", 64'(out_valid), 64'h1);
        chk("flt_verb7_level", 64'(out_level), 64'h4);
        chk("flt_verb7_drop", 64'(cnt_drop), 64'h3);
        tick();

        // 4: backpressure
        do_reset();
        cfg_verbosity = 3'd0; out_ready = 1'b0;
        set_src(0, 3'd1, 2'd1, 32'd0);
        src_valid = 4'b0001;
        for (int m = 0; m < 8; m++) begin
            src_msg[31:0] = 32'(m);
            #1 chk("bp_accept", 64'(src_ready), 64'h1);
            tick();
        end
        src_msg[31:0] = 32'd8;
        #1 chk("bp_full_stall", 64'(src_ready), 64'h0);
        set_src(2, 3'd1, 2'd0, 32'd500);
        src_valid = 4'b0101;
        #1 chk("bp_filtered_ready", 64'(src_ready), 64'h4);
        tick();
        chk("bp_cnt_drop", 64'(cnt_drop), 64'h1);
        chk("bp_cnt_warn8", 64'(cnt_warn), 64'h8);
        src_valid = 4'b0001;
        #1 chk("bp_still_full", 64'(src_ready), 64'h0);
        tick();
        chk("bp_stable_valid", 64'(out_valid), 64'h1);
        chk("bp_stable_msg", 64'(out_msg), 64'h0);
        out_ready = 1'b1;
        #1 chk("bp_no_passthru", 64'(src_ready), 64'h0);
        tick();
        chk("bp_pop1_msg", 64'(out_msg), 64'd1);
        chk("bp_ready_after_pop", 64'(src_ready), 64'h1);
        tick();
        chk("bp_pop2_msg", 64'(out_msg), 64'd2);
        chk("bp_cnt_warn9", 64'(cnt_warn), 64'h9);
        src_valid = '0;
        for (int m = 3; m <= 8; m++) begin
            tick();
            chk("bp_order", 64'(out_msg), 64'(m));
        end
        tick();
        chk("bp_drained", 64'(out_valid), 64'h0);

        // 5: saturation, fatal, clear
        do_reset();
        cfg_verbosity = 3'd4; out_ready = 1'b1;
        set_src(3, 3'd1, 2'd2, 32'd700);
        src_valid = 4'b1000;
        repeat (14) tick();
        chk("cnt_error14", 64'(cnt_error), 64'd14);
        repeat (3) tick();
        chk("cnt_error_sat", 64'(cnt_error), 64'd15);
        chk("cnt_fatal0", 64'(fatal_seen), 64'h0);
        set_src(3, 3'd1, 2'd3, 32'd701);
        tick();
        chk("cnt_fatal1", 64'(cnt_fatal), 64'h1);
        chk("fatal_seen_set", 64'(fatal_seen), 64'h1);
        chk("cnt_error_hold", 64'(cnt_error), 64'd15);
        set_src(3, 3'd1, 2'd2, 32'd702);
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0; src_valid = '0;
        #1;
        chk("clr_error", 64'(cnt_error), 64'h0);
        chk("clr_fatal", 64'(cnt_fatal), 64'h0);
        chk("clr_fatal_seen_kept", 64'(fatal_seen), 64'h1);

        // 6: reset mid-stream
        do_reset();
        out_ready = 1'b0;
        set_src(1, 3'd1, 2'd1, 32'd800);
        src_valid = 4'b0010;
        repeat (3) tick();
        src_valid = '0;
        #1;
        chk("mid_valid", 64'(out_valid), 64'h1);
        chk("mid_cnt_warn", 64'(cnt_warn), 64'h3);
        set_src(2, 3'd1, 2'd1, 32'd900);
        rst = 1'b1; src_valid = 4'b0110;
        #1 chk("mid_rst_ready", 64'(src_ready), 64'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_after_valid", 64'(out_valid), 64'h0);
        chk("mid_after_cnt", 64'(cnt_warn), 64'h0);
        chk("mid_after_fatal", 64'(fatal_seen), 64'h0);
        chk("mid_ptr_zero", 64'(src_ready), 64'h2);
        tick();
        chk("mid_grant_src", 64'(out_src), 64'h1);
        chk("mid_grant_valid", 64'(out_valid), 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/log_event_mux.md
Name: log_event_mux

Overview:
- Synthesizable hardware counterpart of the testbench logger: merges log events from NUM_SRC on-chip sources into one stream.
- Filters INFO events against a runtime verbosity threshold and buffers passing events in a FIFO.
- Keeps saturating per-severity counters and a sticky fatal flag for the test harness to sample.
- Level encoding is NONE=0, LOW=1, MEDIUM=2, HIGH=3, DEBUG=4. Severity encoding is INFO=0, WARN=1, ERROR=2, FATAL=3.

Parameters:
NUM_SRC, 4, number of event sources (>=2)
MSG_WIDTH, 32, payload width per event
FIFO_DEPTH, 8, output FIFO entries (power of 2, >=2)
CNT_WIDTH, 16, width of statistics counters

Ports:
clk  in  1  single clock
rst  in  1  synchronous reset, active-high
src_valid  in  NUM_SRC  per-source event valid
src_ready  out  NUM_SRC  per-source accept; at most one bit high per cycle
src_level  in  3*NUM_SRC  per-source verbosity level, packed, source i at [3i+2:3i]
src_sev  in  2*NUM_SRC  per-source severity, packed
src_msg  in  MSG_WIDTH*NUM_SRC  per-source payload, packed
cfg_verbosity  in  3  threshold level (values 5..7 treated as 4)
cnt_clear  in  1  synchronous clear of counters
out_valid  out  1  FIFO head valid
out_ready  in  1  downstream accept
out_src  out  max(1,$clog2(NUM_SRC))  originating source index
out_level  out  3  level of head event
out_sev  out  2  severity of head event
out_msg  out  MSG_WIDTH  payload of head event
cnt_warn  out  CNT_WIDTH  accepted WARN events
cnt_error  out  CNT_WIDTH  accepted ERROR events
cnt_fatal  out  CNT_WIDTH  accepted FATAL events
cnt_drop  out  CNT_WIDTH  INFO events discarded by filter
fatal_seen  out  1  sticky: any FATAL accepted since reset

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-high (rst).
- Reset values:
  - all counters 0; fatal_seen 0
  - FIFO empty, so out_valid 0 and out_* data 0
  - round-robin pointer 0
  - src_ready all 0 while rst is high
- Reset mid-operation: FIFO contents are discarded, and out_valid is 0 in the cycle after rst is sampled.
- Filter:
  - An event "passes" if sev != INFO, or (cfg_verbosity != 0 and level != 0 and level <= cfg_verbosity).
  - An INFO event that does not pass is "filtered".
- Arbitration:
  - Combinational round-robin over src_valid, starting search at the pointer. The granted index is g.
  - src_ready[g] = filtered(g) ? 1 : !fifo_full. All other src_ready bits are 0.
  - Handshake = src_valid[g] & src_ready[g].
  - On handshake, the pointer becomes (g+1) mod NUM_SRC, wrapping from NUM_SRC-1 to 0.
  - With no handshake, the pointer holds, so a blocked grantee keeps priority.
- FIFO:
  - First-word-fall-through. out_* show the head entry whenever out_valid=1.
  - A passing handshake pushes {g, level, sev, msg}.
  - out_valid & out_ready pops.
  - Latency: an event accepted in cycle N appears on out_* in cycle N+1 at the earliest.
  - Full: passing events are stalled (backpressure only, no loss). Filtered events are still accepted while full.
  - Simultaneous push and pop when not full: count unchanged. No pass-through when full; ready depends on full only, not on out_ready.
  - Empty: out_valid=0; a pop attempt is ignored.
- Counters:
  - Updated on handshake. WARN, ERROR and FATAL increment their own counter; a filtered INFO increments cnt_drop. A passing INFO increments nothing.
  - All counters saturate at all-ones.
  - cnt_clear zeroes all four counters. Clear wins over a same-cycle increment (result 0).
  - fatal_seen sets on a FATAL handshake. It is cleared only by rst, not by cnt_clear.
- out_valid and out_* must stay stable while out_valid=1 and out_ready=0.

Test Plan:
1. Reset then idle: rst high 2 cycles with src_valid=4'b1111 -> src_ready=0 during rst. After release: out_valid=0, all counters 0, fatal_seen=0.
2. Round-robin fairness: all 4 sources hold WARN events, out_ready=1 -> out_src sequence 0,1,2,3,0,...; cnt_warn increments by 1 per cycle; first out_valid one cycle after first accept.
3. Filtering: cfg_verbosity=2. INFO events with levels 1, 2, 3, 0 from source 1 -> levels 1 and 2 emitted; cnt_drop=2. Then cfg_verbosity=0 with an INFO level 1 event -> dropped, cnt_drop=3.
4. Backpressure: out_ready=0, 9 WARN events from source 0 -> 8 accepted, src_ready[0]=0 on the 9th. A filtered INFO from source 2 is still accepted (cnt_drop=1). Raise out_ready -> 9th accepted the cycle after the first pop; order is preserved.
5. Counters: CNT_WIDTH=4, 17 ERROR events -> cnt_error=15 (saturated). FATAL event -> cnt_fatal=1, fatal_seen=1. cnt_clear in the same cycle as an ERROR accept -> cnt_error=0; fatal_seen stays 1.
6. Reset mid-stream: 3 entries in the FIFO, assert rst one cycle -> out_valid=0 next cycle, counters 0, pointer 0 (next grant goes to lowest valid source).
